// File: rtl/mem_arbiter.sv
// Round-robin arbiter that merges instruction fetch and data ports onto one memory port.
// It allows one outstanding transaction at a time.
module mem_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_ready,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_grant_if;
    logic            w_grant_d;
    logic            w_accept;
    logic            w_done;

    logic            r_last_if;
    logic            r_owner_d;
    logic            r_if_ready;
    logic            r_d_ready;
    logic            r_if_valid;
    logic            r_d_valid;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_mem_req;
    logic            r_mem_wen;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [MW-1:0]   r_mem_mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_if_req || i_d_req) w_next_state = S_ISSUE;
            S_ISSUE: if (i_mem_ready)         w_next_state = S_WAIT;
            S_WAIT:  if (i_mem_valid)         w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    // Data wins a tie only when fetch was the last side served.
    always_comb begin
        w_grant_d  = 1'b0;
        w_grant_if = 1'b0;
        w_accept   = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_d  = i_d_req && (!i_if_req || r_last_if);
                w_grant_if = i_if_req && !w_grant_d;
            end
            S_ISSUE: w_accept = i_mem_ready;
            S_WAIT:  w_done   = i_mem_valid;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_if   <= 1'b1;
            r_owner_d   <= 1'b0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
        end else begin
            r_if_ready <= w_grant_if;
            r_d_ready  <= w_grant_d;
            r_if_valid <= w_done && !r_owner_d;
            r_d_valid  <= w_done && r_owner_d;
            if (w_done && !r_owner_d) r_if_rdata <= i_mem_rdata;
            if (w_done && r_owner_d)  r_d_rdata  <= i_mem_rdata;
            // Request fields live only while ISSUE is active.
            if (w_grant_if) begin
                r_last_if   <= 1'b1;
                r_owner_d   <= 1'b0;
                r_mem_req   <= 1'b1;
                r_mem_wen   <= 1'b0;
                r_mem_addr  <= {i_if_addr[AW-1:2], 2'b00};
                r_mem_wdata <= '0;
                r_mem_mask  <= '1;
            end else if (w_grant_d) begin
                r_last_if   <= 1'b0;
                r_owner_d   <= 1'b1;
                r_mem_req   <= 1'b1;
                r_mem_wen   <= i_d_wen;
                r_mem_addr  <= {i_d_addr[AW-1:2], 2'b00};
                r_mem_wdata <= i_d_wdata;
                r_mem_mask  <= i_d_mask;
            end else if (w_accept) begin
                r_mem_req   <= 1'b0;
                r_mem_wen   <= 1'b0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
                r_mem_mask  <= '0;
            end
        end
    end

    assign o_if_ready  = r_if_ready;
    assign o_if_valid  = r_if_valid;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_ready   = r_d_ready;
    assign o_d_valid   = r_d_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mask  = r_mem_mask;
    assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: inputs are driven just after the rising edge
// and outputs are compared at the falling edge.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        ifq, dq, dw, mr, mv;
    logic [31:0] ifa, da, dd, mrd;
    logic [3:0]  dm;
    logic        o_if_ready, o_if_valid, o_d_ready, o_d_valid;
    logic        o_mem_req, o_mem_wen, o_busy;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] F_IFR  = 7'b1000000;
    localparam logic [6:0] F_IFV  = 7'b0100000;
    localparam logic [6:0] F_DR   = 7'b0010000;
    localparam logic [6:0] F_DV   = 7'b0001000;
    localparam logic [6:0] F_MREQ = 7'b0000100;
    localparam logic [6:0] F_MWEN = 7'b0000010;
    localparam logic [6:0] F_BUSY = 7'b0000001;
    localparam logic [31:0] IR3   = 32'h3333_4444;

    typedef struct {
        logic        rst;
        logic        ifq;
        logic [31:0] ifa;
        logic        dq;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [3:0]  dm;
        logic        mr;
        logic        mv;
        logic [31:0] mrd;
        logic [6:0]  f;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] ir;
        logic [31:0] drd;
        logic        xd;
    } vec_t;

    vec_t tbl [23];

    mem_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(ifq), .i_if_addr(ifa),
        .o_if_ready(o_if_ready), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_d_req(dq), .i_d_wen(dw), .i_d_addr(da), .i_d_wdata(dd), .i_d_mask(dm),
        .o_d_ready(o_d_ready), .o_d_valid(o_d_valid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(mr), .i_mem_valid(mv), .i_mem_rdata(mrd),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [138:0] exp_pk(input logic [6:0] f, input logic [3:0] m,
                                            input logic [31:0] a, input logic [31:0] w,
                                            input logic [31:0] ir, input logic [31:0] drd);
        return {f, m, a, w, ir, drd};
    endfunction

    function automatic logic [138:0] outs();
        return {o_if_ready, o_if_valid, o_d_ready, o_d_valid, o_mem_req, o_mem_wen, o_busy,
                o_mem_mask, o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata};
    endfunction

    // ign masks o_d_rdata, which carries no meaning after a store.
    task automatic chk(input string name, input logic [138:0] exp_v, input bit ign);
        logic [138:0] act;
        @(negedge clk);
        act = outs();
        if (ign) begin
            act[31:0]   = '0;
            exp_v[31:0] = '0;
        end
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rst = 1'b0; ifq = 1'b0; ifa = '0; dq = 1'b0; dw = 1'b0; da = '0;
        dd = '0; dm = '0; mr = 1'b0; mv = 1'b0; mrd = '0;
    endtask

    initial begin
        tbl[0]  = '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, 7'h00,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0};
        tbl[1]  = '{1'b0,1'b1,32'h104,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, 7'h00,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0};
        tbl[2]  = '{1'b0,1'b1,32'h104,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,1'b0,32'h0, F_IFR|F_MREQ|F_BUSY,4'hF,32'h104,32'h0,32'h0,32'h0,1'b0};
        tbl[3]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, F_BUSY,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0};
        tbl[4]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h00A00093, F_BUSY,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0};
        tbl[5]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, F_IFV,4'h0,32'h0,32'h0,32'h00A00093,32'h0,1'b0};
        tbl[6]  = '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, 7'h00,4'h0,32'h0,32'h0,32'h00A00093,32'h0,1'b0};
        tbl[7]  = '{1'b0,1'b1,32'h200,1'b1,1'b0,32'h305,32'h0,4'hF,1'b0,1'b0,32'h0, 7'h00,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0};
        tbl[8]  = '{1'b0,1'b1,32'h200,1'b1,1'b0,32'h305,32'h0,4'hF,1'b0,1'b0,32'h0, F_DR|F_MREQ|F_BUSY,4'hF,32'h304,32'h0,32'h0,32'h0,1'b0};
        tbl[9]  = '{1'b0,1'b1,32'h200,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,1'b0,32'h0, F_MREQ|F_BUSY,4'hF,32'h304,32'h0,32'h0,32'h0,1'b0};
        tbl[10] = '{1'b0,1'b1,32'h200,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h11112222, F_BUSY,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0};
        tbl[11] = '{1'b0,1'b1,32'h200,1'b1,1'b0,32'h305,32'h0,4'hF,1'b0,1'b0,32'h0, F_DV,4'h0,32'h0,32'h0,32'h0,32'h11112222,1'b0};
        tbl[12] = '{1'b0,1'b1,32'h200,1'b1,1'b0,32'h305,32'h0,4'hF,1'b1,1'b0,32'h0, F_IFR|F_MREQ|F_BUSY,4'hF,32'h200,32'h0,32'h0,32'h11112222,1'b0};
        tbl[13] = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h305,32'h0,4'hF,1'b0,1'b1,IR3, F_BUSY,4'h0,32'h0,32'h0,32'h0,32'h11112222,1'b0};
        tbl[14] = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h305,32'h0,4'hF,1'b0,1'b0,32'h0, F_IFV,4'h0,32'h0,32'h0,IR3,32'h11112222,1'b0};
        tbl[15] = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h305,32'h0,4'hF,1'b1,1'b0,32'h0, F_DR|F_MREQ|F_BUSY,4'hF,32'h304,32'h0,IR3,32'h11112222,1'b0};
        tbl[16] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h55, F_BUSY,4'h0,32'h0,32'h0,IR3,32'h11112222,1'b0};
        tbl[17] = '{1'b0,1'b0,32'h0,1'b1,1'b1,32'h2003,32'hAB000000,4'h8,1'b0,1'b1,32'hDEADBEEF, F_DV,4'h0,32'h0,32'h0,IR3,32'h55,1'b0};
        tbl[18] = '{1'b0,1'b0,32'h0,1'b1,1'b1,32'h2003,32'hAB000000,4'h8,1'b0,1'b1,32'hCAFEF00D, F_DR|F_MREQ|F_MWEN|F_BUSY,4'h8,32'h2000,32'hAB000000,IR3,32'h55,1'b0};
        tbl[19] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,1'b0,32'h0, F_MREQ|F_MWEN|F_BUSY,4'h8,32'h2000,32'hAB000000,IR3,32'h55,1'b0};
        tbl[20] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h12345678, F_BUSY,4'h0,32'h0,32'h0,IR3,32'h55,1'b0};
        tbl[21] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, F_DV,4'h0,32'h0,32'h0,IR3,32'h0,1'b1};
        tbl[22] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0, 7'h00,4'h0,32'h0,32'h0,IR3,32'h0,1'b1};

        clr_in();
        rst = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            cyc();
            rst = tbl[i].rst; ifq = tbl[i].ifq; ifa = tbl[i].ifa;
            dq = tbl[i].dq; dw = tbl[i].dw; da = tbl[i].da; dd = tbl[i].dd; dm = tbl[i].dm;
            mr = tbl[i].mr; mv = tbl[i].mv; mrd = tbl[i].mrd;
            chk($sformatf("vec%0d", i),
                exp_pk(tbl[i].f, tbl[i].m, tbl[i].a, tbl[i].w, tbl[i].ir, tbl[i].drd), tbl[i].xd);
        end

        // Memory backpressure: five ISSUE cycles with ready low, then one with ready high.
        cyc(); clr_in(); ifq = 1'b1; ifa = 32'h41;
        chk("bp_idle", exp_pk(7'h00, 4'h0, 32'h0, 32'h0, IR3, 32'h0), 1'b1);
        cyc();
        chk("bp_grant", exp_pk(F_IFR|F_MREQ|F_BUSY, 4'hF, 32'h40, 32'h0, IR3, 32'h0), 1'b1);
        for (int k = 2; k <= 5; k++) begin
            cyc(); ifq = 1'b0;
            chk($sformatf("bp_hold%0d", k), exp_pk(F_MREQ|F_BUSY, 4'hF, 32'h40, 32'h0, IR3, 32'h0), 1'b1);
        end
        cyc(); mr = 1'b1;
        chk("bp_accept", exp_pk(F_MREQ|F_BUSY, 4'hF, 32'h40, 32'h0, IR3, 32'h0), 1'b1);
        cyc(); mr = 1'b0; mv = 1'b1; mrd = 32'h0BADF00D;
        chk("bp_wait", exp_pk(F_BUSY, 4'h0, 32'h0, 32'h0, IR3, 32'h0), 1'b1);
        cyc(); mv = 1'b0;
        chk("bp_valid", exp_pk(F_IFV, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 32'h0), 1'b1);

        // Reset while waiting on memory, followed by a late completion.
        cyc(); dq = 1'b1; da = 32'h80; dm = 4'hF;
        chk("rw_idle", exp_pk(7'h00, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 32'h0), 1'b1);
        cyc(); mr = 1'b1;
        chk("rw_grant", exp_pk(F_DR|F_MREQ|F_BUSY, 4'hF, 32'h80, 32'h0, 32'h0BADF00D, 32'h0), 1'b1);
        cyc(); dq = 1'b0; mr = 1'b0; rst = 1'b1;
        chk("rw_wait", exp_pk(F_BUSY, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 32'h0), 1'b1);
        cyc(); rst = 1'b0; mv = 1'b1; mrd = 32'h99;
        chk("rw_reset", exp_pk(7'h00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
        cyc(); mv = 1'b0; ifq = 1'b1; ifa = 32'h10;
        chk("rw_late", exp_pk(7'h00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
        cyc(); mr = 1'b1;
        chk("rw_regrant", exp_pk(F_IFR|F_MREQ|F_BUSY, 4'hF, 32'h10, 32'h0, 32'h0, 32'h0), 1'b0);
        cyc(); ifq = 1'b0; mr = 1'b0;
        chk("rw_wait2", exp_pk(F_BUSY, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
        cyc(); mv = 1'b1; mrd = 32'h77;
        chk("rw_wait3", exp_pk(F_BUSY, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
        cyc(); mv = 1'b0;
        chk("rw_done", exp_pk(F_IFV, 4'h0, 32'h0, 32'h0, 32'h77, 32'h0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
